// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the I-cache / D-cache main-memory port arbiter.
// Grant states, parameter defaults and the memory-port strobe encodings.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  localparam int unsigned MAX_BEATS_DEF = 4;
  localparam int unsigned CNT_W_DEF     = 21;

  localparam logic [3:0] WSTRB_READ = 4'h0;
  localparam logic [3:0] WSTRB_WORD = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating statistics counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 21
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory port between I-cache (m0)
// and D-cache (m1), with bounded locked bursts and per-master statistics.
//
//   state   | meaning
//   IDLE    | no grant; memory port quiet, picks next master
//   GNT0    | m0 owns the memory port
//   GNT1    | m1 owns the memory port
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BEATS = MAX_BEATS_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_valid,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  m0_xfers,
  output logic [CNT_W-1:0]  m1_xfers,
  output logic [CNT_W-1:0]  m0_wait,
  output logic [CNT_W-1:0]  m1_wait
);

  localparam int unsigned BEAT_W = $clog2(MAX_BEATS) + 1;
  // beats_q holds completed beats before this one; burst may continue while below this
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic              sel1, sel_valid, sel_lock;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      beats_q <= beats_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    beats_d   = beats_q;
    sel1      = 1'b0;
    sel_valid = 1'b0;
    sel_lock  = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = WSTRB_READ;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;

    unique case (state_q)
      ST_IDLE: begin
        beats_d = '0;
        if (m0_valid && m1_valid) begin
          state_d = last_q ? ST_GNT0 : ST_GNT1;
        end else if (m0_valid) begin
          state_d = ST_GNT0;
        end else if (m1_valid) begin
          state_d = ST_GNT1;
        end
      end

      ST_GNT0, ST_GNT1: begin
        sel1 = (state_q == ST_GNT1);
        if (sel1) begin
          sel_valid = m1_valid;
          sel_lock  = m1_lock;
          mem_addr  = m1_addr;
          mem_wdata = m1_wdata;
          mem_wstrb = m1_wstrb;
          m1_ready  = mem_ready;
          m1_rdata  = mem_rdata;
        end else begin
          sel_valid = m0_valid;
          sel_lock  = m0_lock;
          mem_addr  = m0_addr;
          mem_wdata = m0_wdata;
          mem_wstrb = m0_wstrb;
          m0_ready  = mem_ready;
          m0_rdata  = mem_rdata;
        end
        mem_valid = sel_valid;

        if (mem_ready) begin
          beats_d = beats_q + {{(BEAT_W-1){1'b0}}, 1'b1};
          if (!(sel_lock && (beats_q < LAST_BEAT))) begin
            state_d = ST_IDLE;
            last_d  = sel1;
          end
        end else if (!sel_valid && !sel_lock) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_m0_xfers (
    .clk   (clk),
    .clr_i (reset),
    .en_i  (m0_ready),
    .cnt_o (m0_xfers)
  );

  sat_counter #(.W(CNT_W)) u_m1_xfers (
    .clk   (clk),
    .clr_i (reset),
    .en_i  (m1_ready),
    .cnt_o (m1_xfers)
  );

  sat_counter #(.W(CNT_W)) u_m0_wait (
    .clk   (clk),
    .clr_i (reset),
    .en_i  (m0_valid && (state_q != ST_GNT0)),
    .cnt_o (m0_wait)
  );

  sat_counter #(.W(CNT_W)) u_m1_wait (
    .clk   (clk),
    .clr_i (reset),
    .en_i  (m1_valid && (state_q != ST_GNT1)),
    .cnt_o (m1_wait)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a latency-programmable memory model
// checks request order, per-master queues check returned read data.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_valid = 1'b0, m0_lock = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic [3:0]  m0_wstrb = '0;
  logic        m1_valid = 1'b0, m1_lock = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m1_wstrb = '0;
  logic        m0_ready, m1_ready, mem_valid;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [CW-1:0] m0_xfers, m1_xfers, m0_wait, m1_wait;

  int n_chk = 0;
  int n_err = 0;

  int mem_lat = 1;
  int mem_cnt = 0;
  bit mem_auto = 1'b1;
  bit force_pulse = 1'b0;

  logic [67:0] exp_mem_q[$];
  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BEATS(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .m0_xfers(m0_xfers), .m1_xfers(m1_xfers), .m0_wait(m0_wait), .m1_wait(m1_wait)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    logic [31:0] r;
    r = {a[15:0], ~a[15:0]};
    if (a == 32'h100) r = 32'hDEADBEEF;
    return r;
  endfunction

  // memory model: ready after mem_lat cycles of mem_valid, checks request order
  always @(posedge clk) begin
    #2;
    if (!mem_auto) begin
      mem_cnt   = 0;
      mem_ready = force_pulse;
      mem_rdata = 32'hBAD0BAD0;
    end else if (mem_ready) begin
      mem_ready = 1'b0;
      mem_cnt   = 0;
    end else if (mem_valid) begin
      if (mem_cnt >= mem_lat) begin
        mem_ready = 1'b1;
        mem_rdata = mem_fn(mem_addr);
        if (exp_mem_q.size() == 0) chk("mem_unexpected_req", 96'(mem_addr), 96'(0));
        else chk("mem_req", 96'({mem_addr, mem_wdata, mem_wstrb}), 96'(exp_mem_q.pop_front()));
      end else begin
        mem_cnt++;
      end
    end else begin
      mem_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (m0_ready) begin
      if (exp0_q.size() == 0) chk("m0_unexpected_ready", 96'(1), 96'(0));
      else chk("m0_rdata", 96'(m0_rdata), 96'(exp0_q.pop_front()));
    end
    if (m1_ready) begin
      if (exp1_q.size() == 0) chk("m1_unexpected_ready", 96'(1), 96'(0));
      else chk("m1_rdata", 96'(m1_rdata), 96'(exp1_q.pop_front()));
    end
  end

  task automatic drive(input int m, input logic v, input logic l, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ws);
    if (m == 0) begin
      m0_valid = v; m0_lock = l; m0_addr = a; m0_wdata = wd; m0_wstrb = ws;
    end else begin
      m1_valid = v; m1_lock = l; m1_addr = a; m1_wdata = wd; m1_wstrb = ws;
    end
  endtask

  task automatic exp_mem(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    exp_mem_q.push_back({a, wd, ws});
  endtask

  // chk_mode 1: port already ours (locked continuation); 2: check IDLE->grant latency
  task automatic xfer(input int m, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input logic lk, input int chk_mode);
    int n;
    bit got;
    drive(m, 1'b1, lk, a, wd, ws);
    if (m == 0) exp0_q.push_back(mem_fn(a));
    else exp1_q.push_back(mem_fn(a));
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (chk_mode == 1 && n == 1) chk("no_bubble", 96'({mem_valid, mem_addr}), 96'({1'b1, a}));
      if (chk_mode == 2 && n == 1) chk("grant_cycle_n", 96'(mem_valid), 96'(0));
      if (chk_mode == 2 && n == 2) chk("grant_cycle_n1", 96'(mem_valid), 96'(1));
      got = (m == 0) ? m0_ready : m1_ready;
    end
    if (!got) chk("ready_timeout", 96'(0), 96'(1));
    @(posedge clk);
    #1;
    drive(m, 1'b0, lk, a, wd, WSTRB_READ);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_counters(input string tag, input int x0, input int x1, input int w0, input int w1);
    @(negedge clk);
    chk({tag, "_m0_xfers"}, 96'(m0_xfers), 96'(x0));
    chk({tag, "_m1_xfers"}, 96'(m1_xfers), 96'(x1));
    chk({tag, "_m0_wait"},  96'(m0_wait),  96'(w0));
    chk({tag, "_m1_wait"},  96'(m1_wait),  96'(w1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_mem_port", 96'({mem_valid, mem_addr, mem_wdata, mem_wstrb}), 96'(0));
    chk("rst_ready_rdata", 96'({m0_ready, m1_ready, m0_rdata, m1_rdata}), 96'(0));
    chk("rst_counters", 96'({m0_xfers, m1_xfers, m0_wait, m1_wait}), 96'(0));
    @(posedge clk);
    #1;

    // single m0 read, grant latency and read data
    mem_lat = 2;
    exp_mem(32'h100, 32'h0, WSTRB_READ);
    xfer(0, 32'h100, 32'h0, WSTRB_READ, 1'b0, 2);
    chk_counters("t1", 1, 0, 1, 0);

    // ties: m1 wins first after reset, then last_served alternates
    do_reset();
    mem_lat = 1;
    exp_mem(32'h1004, 32'h0, WSTRB_READ);
    exp_mem(32'h1000, 32'h0, WSTRB_READ);
    fork
      xfer(0, 32'h1000, 32'h0, WSTRB_READ, 1'b0, 0);
      xfer(1, 32'h1004, 32'h0, WSTRB_READ, 1'b0, 0);
    join
    exp_mem(32'h1104, 32'h0, WSTRB_READ);
    xfer(1, 32'h1104, 32'h0, WSTRB_READ, 1'b0, 0);
    exp_mem(32'h1200, 32'h55AA55AA, 4'h3);
    exp_mem(32'h1204, 32'h0, WSTRB_READ);
    fork
      xfer(0, 32'h1200, 32'h55AA55AA, 4'h3, 1'b0, 0);
      xfer(1, 32'h1204, 32'h0, WSTRB_READ, 1'b0, 0);
    join
    @(negedge clk);
    chk("t2_m0_xfers", 96'(m0_xfers), 96'(2));
    chk("t2_m1_xfers", 96'(m1_xfers), 96'(3));
    @(posedge clk);
    #1;

    // locked 4-beat m0 refill while m1 write waits
    do_reset();
    mem_lat = 1;
    for (int i = 0; i < 4; i++) exp_mem(32'h200 + 32'(4 * i), 32'h0, WSTRB_READ);
    exp_mem(32'h300, 32'h12345678, WSTRB_WORD);
    fork
      begin
        xfer(0, 32'h200, 32'h0, WSTRB_READ, 1'b1, 0);
        xfer(0, 32'h204, 32'h0, WSTRB_READ, 1'b1, 1);
        xfer(0, 32'h208, 32'h0, WSTRB_READ, 1'b1, 1);
        xfer(0, 32'h20C, 32'h0, WSTRB_READ, 1'b0, 1);
      end
      begin
        @(posedge clk);
        #1;
        xfer(1, 32'h300, 32'h12345678, WSTRB_WORD, 1'b0, 0);
      end
    join
    chk_counters("t3", 4, 1, 1, 12);

    // lock held past MAX_BEATS: grant released after beat 4, m1 served before beat 5
    do_reset();
    mem_lat = 1;
    for (int i = 0; i < 4; i++) exp_mem(32'h400 + 32'(4 * i), 32'h0, WSTRB_READ);
    exp_mem(32'h500, 32'h0, WSTRB_READ);
    exp_mem(32'h410, 32'h0, WSTRB_READ);
    exp_mem(32'h414, 32'h0, WSTRB_READ);
    fork
      begin
        xfer(0, 32'h400, 32'h0, WSTRB_READ, 1'b1, 0);
        xfer(0, 32'h404, 32'h0, WSTRB_READ, 1'b1, 1);
        xfer(0, 32'h408, 32'h0, WSTRB_READ, 1'b1, 1);
        xfer(0, 32'h40C, 32'h0, WSTRB_READ, 1'b1, 1);
        xfer(0, 32'h410, 32'h0, WSTRB_READ, 1'b1, 0);
        xfer(0, 32'h414, 32'h0, WSTRB_READ, 1'b0, 1);
      end
      begin
        @(posedge clk);
        #1;
        xfer(1, 32'h500, 32'h0, WSTRB_READ, 1'b0, 0);
      end
    join
    chk_counters("t4", 6, 1, 5, 12);

    // reset in the middle of an m1 write; late mem_ready must be ignored
    do_reset();
    mem_auto = 1'b0;
    drive(1, 1'b1, 1'b0, 32'h600, 32'hCAFEF00D, WSTRB_WORD);
    repeat (2) @(negedge clk);
    chk("t5_granted", 96'({mem_valid, mem_addr, mem_wstrb}), 96'({1'b1, 32'h600, 4'hF}));
    chk("t5_wait_before", 96'(m1_wait), 96'(1));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    force_pulse = 1'b1;
    @(negedge clk);
    chk("t5_mem_after_rst", 96'({mem_valid, mem_addr, mem_wdata, mem_wstrb}), 96'(0));
    chk("t5_late_ready", 96'({mem_ready, m0_ready, m1_ready, m0_rdata, m1_rdata}), 96'({1'b1, 66'h0}));
    chk("t5_counters", 96'({m0_xfers, m1_xfers, m0_wait, m1_wait}), 96'(0));
    @(posedge clk);
    #1;
    force_pulse = 1'b0;
    @(negedge clk);
    chk("t5_no_xfer", 96'({m1_xfers, mem_valid}), 96'(0));
    @(posedge clk);
    #1;
    mem_auto = 1'b1;

    // counter saturation: 20 unlocked m0 beats into 4-bit counters
    do_reset();
    mem_lat = 0;
    for (int i = 0; i < 20; i++) begin
      exp_mem(32'h700 + 32'(4 * i), 32'h0, WSTRB_READ);
      xfer(0, 32'h700 + 32'(4 * i), 32'h0, WSTRB_READ, 1'b0, 0);
    end
    chk_counters("t6", 15, 0, 15, 0);

    chk("mem_queue_drained", 96'(exp_mem_q.size()), 96'(0));
    chk("m0_queue_drained", 96'(exp0_q.size()), 96'(0));
    chk("m1_queue_drained", 96'(exp1_q.size()), 96'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
